// File: rtl/scarv_cop_aes_pkg.sv
// Shared encodings for the coprocessor AES word sequencer.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package scarv_cop_aes_pkg;

    typedef enum logic [1:0] {
        AES_OP_SUB    = 2'd0,
        AES_OP_INVSUB = 2'd1,
        AES_OP_SUBROT = 2'd2,
        AES_OP_RSVD   = 2'd3
    } aes_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } aes_state_e;

    // Beats needed to push four bytes through the given number of S-box lanes.
    function automatic int unsigned aes_beats(input int unsigned lanes);
        return (lanes == 0) ? 0 : 4 / lanes;
    endfunction

endpackage

// File: rtl/scarv_cop_aes_sbox.sv
// Single-byte AES S-box, forward or inverse, built from GF(2^8) inversion plus affine maps.
// Latency: purely combinational.
// Backpressure: none; the output follows the input every cycle.
module scarv_cop_aes_sbox (
    input  logic [7:0] in_byte,
    input  logic       inv,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // Multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
    endfunction

    logic [7:0] pre_byte;
    logic [7:0] inv_byte;

    // Forward: invert then affine. Inverse: undo affine then invert.
    always_comb begin
        pre_byte = inv ? aff_inv(in_byte) : in_byte;
        inv_byte = gf_inv(pre_byte);
        out_byte = inv ? inv_byte : aff_fwd(inv_byte);
    end

endmodule

// File: rtl/scarv_cop_aes_word_seq.sv
// Streams a 32-bit word through LANES shared S-boxes for SubWord / InvSubWord / SubWord(RotWord).
// Latency: result valid 4/LANES cycles after the accept edge; reserved op reports after 1 cycle.
// Backpressure: result held in DONE until out_ready; no new request accepted until then.
module scarv_cop_aes_word_seq #(
    parameter int LANES = 1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_word,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        out_err
);
    import scarv_cop_aes_pkg::*;

    localparam int unsigned BEATS     = aes_beats(LANES);
    localparam logic [1:0]  LAST_BEAT = 2'(BEATS - 1);

    if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
        $error("scarv_cop_aes_word_seq: LANES must be 1, 2 or 4");
    end

    aes_state_e  state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    aes_op_e     op_q, op_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] res_q, res_d;
    logic        err_q, err_d;

    logic [1:0]  lane_pos [LANES];
    logic [7:0]  lane_in  [LANES];
    logic [7:0]  lane_out [LANES];
    logic        sbox_inv;

    assign sbox_inv = (op_q == AES_OP_INVSUB);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        // Byte slot handled by this lane on the current beat (beat*LANES+k, always < 4;
        // with four lanes the beat term wraps to zero, which is the only beat there is).
        assign lane_pos[k] = beat_q * 2'(LANES) + 2'(k);
        // A reserved op passes through BUSY with the S-box inputs parked at zero.
        assign lane_in[k]  = err_q ? 8'h00 : opnd_q[{lane_pos[k], 3'b000} +: 8];

        scarv_cop_aes_sbox u_sbox (
            .in_byte  (lane_in[k]),
            .inv      (sbox_inv),
            .out_byte (lane_out[k])
        );
    end

    // Next-state logic: accept, beat sequencing, handoff; flush overrides everything.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        res_d   = res_q;
        err_d   = err_q;
        if (flush) begin
            state_d = ST_IDLE;
            beat_d  = 2'd0;
            res_d   = 32'h0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_d   = aes_op_e'(in_op);
                        opnd_d = (in_op == AES_OP_SUBROT) ? {in_word[7:0], in_word[31:8]} : in_word;
                        res_d  = 32'h0;
                        err_d  = (in_op == AES_OP_RSVD);
                        // Reserved op spends exactly one cycle in BUSY, writing nothing.
                        beat_d  = (in_op == AES_OP_RSVD) ? LAST_BEAT : 2'd0;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!err_q) begin
                        for (int k = 0; k < LANES; k++) begin
                            res_d[{lane_pos[k], 3'b000} +: 8] = lane_out[k];
                        end
                    end
                    beat_d = beat_q + 2'd1;
                    if (beat_q == LAST_BEAT) state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counter, operand and result registers with synchronous reset.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= ST_IDLE;
            beat_q  <= 2'd0;
            op_q    <= AES_OP_SUB;
            opnd_q  <= 32'h0;
            res_q   <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE) && !g_reset;
    assign out_valid = (state_q == ST_DONE);
    assign out_word  = res_q;
    assign out_err   = err_q;

endmodule

// File: tb/tb_scarv_cop_aes_word_seq.sv
// Bench for the AES word sequencer: three instances (LANES 1, 2, 4) share one stimulus stream.
// Latency: each instance is compared every cycle against a transaction-level model.
// Backpressure: out_ready is driven both in directed holds and randomly.
module tb_scarv_cop_aes_word_seq;

    logic        g_clk;
    logic        g_reset;
    logic        in_valid;
    logic [1:0]  in_op;
    logic [31:0] in_word;
    logic        flush;
    logic        out_ready;

    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_err   [3];
    logic [31:0] out_word  [3];

    scarv_cop_aes_word_seq #(.LANES(1)) u_dut_l1 (
        .g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_op(in_op), .in_word(in_word), .flush(flush), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_word(out_word[0]), .out_err(out_err[0])
    );
    scarv_cop_aes_word_seq #(.LANES(2)) u_dut_l2 (
        .g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_op(in_op), .in_word(in_word), .flush(flush), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_word(out_word[1]), .out_err(out_err[1])
    );
    scarv_cop_aes_word_seq #(.LANES(4)) u_dut_l4 (
        .g_clk(g_clk), .g_reset(g_reset), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_op(in_op), .in_word(in_word), .flush(flush), .out_valid(out_valid[2]),
        .out_ready(out_ready), .out_word(out_word[2]), .out_err(out_err[2])
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference tables, built from field arithmetic and a brute-force inverse search.
    logic [7:0] sb_t  [256];
    logic [7:0] isb_t [256];

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        int acc, x, y;
        acc = 0; x = int'(a); y = int'(b);
        while (y != 0) begin
            if (y % 2 == 1) acc = acc ^ x;
            x = x * 2;
            if (x >= 256) x = x ^ 'h11B;
            y = y / 2;
        end
        return 8'(acc);
    endfunction

    function automatic logic [7:0] m_affine(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] c;
        c = 8'h63;
        for (int i = 0; i < 8; i++)
            r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
        return r;
    endfunction

    task automatic build_tables();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] iv;
            iv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (m_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            sb_t[x] = m_affine(iv);
        end
        for (int x = 0; x < 256; x++) isb_t[sb_t[x]] = 8'(x);
    endtask

    function automatic logic [31:0] model_word(input logic [1:0] op, input logic [31:0] w);
        logic [31:0] s, r;
        s = (op == 2'd2) ? {w[7:0], w[31:8]} : w;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = (op == 2'd1) ? isb_t[s[8*i +: 8]] : sb_t[s[8*i +: 8]];
        return r;
    endfunction

    function automatic int cycles_for(input int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 2 : 1;
    endfunction

    // Transaction-level model per instance: 0 idle, 1 working (countdown), 2 holding result.
    int          m_st   [3];
    int          m_cnt  [3];
    logic [31:0] m_word [3];
    logic        m_err  [3];
    bit          m_zero [3];
    bit          cur_rst;

    // Latency / result capture from the DUT, for the literal expectations.
    int          acc_cnt   [3];
    int          seen_lat  [3];
    logic [31:0] seen_word [3];
    logic        seen_err  [3];

    task automatic chk_bit(input string name, input int idx, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[L%0d] t=%0t: got %0b expected %0b", name, cycles_for(2 - idx), $time, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[L%0d] t=%0t: got 0x%08h expected 0x%08h", name, cycles_for(2 - idx), $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s[L%0d] t=%0t: got %0d expected %0d", name, cycles_for(2 - idx), $time, act, exp);
        end
    endtask

    task automatic model_next(input bit rst, input bit fl, input bit iv, input logic [1:0] op,
                              input logic [31:0] w, input bit ordy);
        for (int i = 0; i < 3; i++) begin
            if (rst || fl) begin
                m_st[i] = 0; m_zero[i] = 1'b1; acc_cnt[i] = -1;
            end else if (m_st[i] == 0) begin
                if (iv) begin
                    m_zero[i] = 1'b0; acc_cnt[i] = 0; seen_lat[i] = -1;
                    m_st[i] = 1;
                    if (op == 2'd3) begin
                        m_cnt[i] = 1; m_word[i] = 32'h0; m_err[i] = 1'b1;
                    end else begin
                        m_cnt[i] = cycles_for(i); m_word[i] = model_word(op, w); m_err[i] = 1'b0;
                    end
                end
            end else if (m_st[i] == 1) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) m_st[i] = 2;
            end else if (ordy) begin
                m_st[i] = 0;
            end
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 3; i++) begin
            chk_bit("in_ready", i, in_ready[i], (m_st[i] == 0) && !cur_rst);
            chk_bit("out_valid", i, out_valid[i], m_st[i] == 2);
            if (m_st[i] == 2 || m_zero[i]) begin
                chk_word("out_word", i, out_word[i], m_zero[i] ? 32'h0 : m_word[i]);
                chk_bit("out_err", i, out_err[i], m_zero[i] ? 1'b0 : m_err[i]);
            end
            if (acc_cnt[i] >= 0) begin
                if (out_valid[i] && seen_lat[i] < 0) begin
                    seen_lat[i] = acc_cnt[i]; seen_word[i] = out_word[i]; seen_err[i] = out_err[i];
                end
                acc_cnt[i]++;
            end
        end
    endtask

    // One clock: drive inputs, advance the model, sample just after the edge.
    task automatic step(input bit rst, input bit fl, input bit iv, input logic [1:0] op,
                        input logic [31:0] w, input bit ordy);
        g_reset = rst; flush = fl; in_valid = iv; in_op = op; in_word = w; out_ready = ordy;
        cur_rst = rst;
        model_next(rst, fl, iv, op, w, ordy);
        @(posedge g_clk);
        #1;
        compare();
        @(negedge g_clk);
    endtask

    task automatic idle_step(input bit ordy);
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, ordy);
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] w,
                          input logic [31:0] exp_w, input logic exp_e);
        step(1'b0, 1'b0, 1'b1, op, w, 1'b1);
        repeat (6) idle_step(1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_int({tag, "_latency"}, i, seen_lat[i], (op == 2'd3) ? 1 : (i == 0 ? 4 : i == 1 ? 2 : 1));
            chk_word({tag, "_word"}, i, seen_word[i], exp_w);
            chk_bit({tag, "_err"}, i, seen_err[i], exp_e);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_word[i] = 32'h0; m_err[i] = 1'b0; m_zero[i] = 1'b1;
            acc_cnt[i] = -1; seen_lat[i] = -1; seen_word[i] = 32'h0; seen_err[i] = 1'b0;
        end
        build_tables();

        // Reset: in_ready low while reset is asserted, outputs zero.
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 2'd0, 32'h0, 1'b1);
        chk_bit("rst_in_ready", 0, in_ready[0], 1'b0);
        chk_word("rst_out_word", 0, out_word[0], 32'h0);
        idle_step(1'b1);
        chk_bit("post_rst_in_ready", 0, in_ready[0], 1'b1);

        // Main function on each op, literal results and per-LANES latency.
        run_op("sub", 2'd0, 32'h00112233, 32'h638293C3, 1'b0);
        run_op("invsub", 2'd1, 32'h7C637C63, 32'h01000100, 1'b0);
        run_op("subrot", 2'd2, 32'h00112233, 32'hC3638293, 1'b0);
        run_op("rsvd", 2'd3, 32'hDEADBEEF, 32'h00000000, 1'b1);

        // Back-pressure: result held 10+ cycles, stray in_valid pulse ignored.
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h00112233, 1'b0);
        for (int j = 0; j < 12; j++) step(1'b0, 1'b0, j == 6, 2'd0, 32'hFFFFFFFF, 1'b0);
        chk_bit("hold_valid", 0, out_valid[0], 1'b1);
        chk_word("hold_word", 0, out_word[0], 32'h638293C3);
        chk_bit("hold_in_ready", 0, in_ready[0], 1'b0);
        idle_step(1'b1);
        chk_bit("after_handoff_in_ready", 0, in_ready[0], 1'b1);

        // Flush during beat 2, then a clean op shows no stale bytes.
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'hFFFFFFFF, 1'b1);
        idle_step(1'b1);
        idle_step(1'b1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 1'b1);
        chk_int("flush_no_valid", 0, seen_lat[0], -1);
        chk_word("flush_word", 0, out_word[0], 32'h0);
        chk_bit("flush_in_ready", 0, in_ready[0], 1'b1);
        run_op("after_flush", 2'd0, 32'h00000000, 32'h63636363, 1'b0);

        // Flush and in_valid together in IDLE: request dropped.
        step(1'b0, 1'b1, 1'b1, 2'd0, 32'h12345678, 1'b1);
        idle_step(1'b1);
        chk_bit("flush_wins_valid", 0, out_valid[0], 1'b0);
        chk_bit("flush_wins_ready", 0, in_ready[0], 1'b1);

        // Synchronous reset mid-BUSY.
        step(1'b0, 1'b0, 1'b1, 2'd0, 32'h00112233, 1'b1);
        idle_step(1'b1);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1);
        chk_bit("midrst_in_ready", 0, in_ready[0], 1'b0);
        chk_bit("midrst_valid", 0, out_valid[0], 1'b0);
        chk_word("midrst_word", 0, out_word[0], 32'h0);
        idle_step(1'b1);
        chk_bit("midrst_after_ready", 0, in_ready[0], 1'b1);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
